float_to_fxp: RTL and testbench

Converts one IEEE-754 single-precision value into a signed 32-bit two's-complement fixed-point word with FRAC_BITS fractional bits (default Q16.16). It is the input-format stage of the inverse-square-root datapath: the float operand is converted here before the fixed-point core uses it. Conversion runs under a start/ready four-phase handshake with fixed latency.

---
 rtl/float_fxp_pkg.sv | 18 +
 rtl/float_to_fxp_if.sv | 10 +
 rtl/float_to_fxp_core.sv | 54 +++++
 rtl/float_to_fxp.sv | 62 ++++++
 tb/tb_float_to_fxp.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/float_fxp_pkg.sv
// Shared constants and FSM encoding for the float -> fixed-point converter.
package float_fxp_pkg;

  localparam int FLOAT_BIAS = 127;
  localparam int MANT_W     = 23;
  localparam int EXP_W      = 8;
  localparam int FXP_W      = 32;

  localparam logic [FXP_W-1:0] FXP_MAX = 32'h7FFF_FFFF;
  localparam logic [FXP_W-1:0] FXP_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/float_to_fxp_if.sv
// Request/result bundle between a requester (master) and the converter (slave).
interface float_to_fxp_if;
  logic        start;
  logic [31:0] float_in;
  logic [31:0] fxp_out;
  logic        ready;

  modport master (output start, output float_in, input fxp_out, input ready);
  modport slave  (input start, input float_in, output fxp_out, output ready);
endinterface

// File: rtl/float_to_fxp_core.sv
// Combinational IEEE-754 single -> signed fixed-point conversion with
// truncation toward zero and saturation.
import float_fxp_pkg::*;

module float_to_fxp_core #(
  parameter int FRAC_BITS = 16
) (
  input  logic [31:0] float_i,
  output logic [31:0] fxp_o
);

  logic              sign;
  logic [EXP_W-1:0]  e;
  logic [MANT_W-1:0] mant;
  logic [MANT_W:0]   m;
  int                sh;
  logic [FXP_W-1:0]  mag;
  logic              ovf;

  assign sign = float_i[31];
  assign e    = float_i[30:23];
  assign mant = float_i[22:0];
  assign m    = {1'b1, mant};

  // Barrel shift of the significand; any left shift past 8 pushes the
  // hidden one beyond bit 31, so that is flagged as overflow directly.
  always_comb begin
    mag = '0;
    ovf = 1'b0;
    sh  = int'(e) - FLOAT_BIAS - MANT_W + FRAC_BITS;
    if (sh >= 0) begin
      if (sh > (FXP_W - 1 - MANT_W)) ovf = 1'b1;
      else                           mag = {8'b0, m} << sh[3:0];
    end else if (sh > -(MANT_W + 1)) begin
      mag = {8'b0, m} >> 5'(-sh);
    end
  end

  // Special encodings, saturation, then sign application.
  always_comb begin
    fxp_o = '0;
    if (e == '0) begin
      fxp_o = '0;
    end else if (e == '1) begin
      fxp_o = (mant != '0 || !sign) ? FXP_MAX : FXP_MIN;
    end else if (!sign) begin
      fxp_o = (ovf || mag[31]) ? FXP_MAX : mag;
    end else begin
      // -2^31 is representable, so only strictly larger magnitudes clamp.
      fxp_o = (ovf || mag > FXP_MIN) ? FXP_MIN : -mag;
    end
  end

endmodule

// File: rtl/float_to_fxp.sv
// Handshaked float -> fixed-point stage: capture in IDLE, convert in CALC,
// hold the result with ready high in DONE until start drops.
import float_fxp_pkg::*;

module float_to_fxp #(
  parameter int FRAC_BITS = 16
) (
  input  logic         clk,
  input  logic         rst,
  float_to_fxp_if.slave bus
);

  state_t      state_q, state_d;
  logic [31:0] cap_q, cap_d;
  logic [31:0] fxp_q, fxp_d;
  logic        ready_q, ready_d;
  logic [31:0] conv;

  float_to_fxp_core #(.FRAC_BITS(FRAC_BITS)) u_core (
    .float_i (cap_q),
    .fxp_o   (conv)
  );

  // State and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cap_q   <= '0;
      fxp_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      fxp_q   <= fxp_d;
      ready_q <= ready_d;
    end
  end

  // Next-state: one conversion per start pulse, start must drop to re-arm.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    state_d = DONE;
      DONE:    if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register next values: capture operand on accept, latch result out of CALC.
  always_comb begin
    cap_d   = cap_q;
    fxp_d   = fxp_q;
    ready_d = (state_d == DONE);
    if (state_q == IDLE && bus.start) cap_d = bus.float_in;
    if (state_q == CALC)              fxp_d = conv;
  end

  assign bus.fxp_out = fxp_q;
  assign bus.ready   = ready_q;

endmodule

// File: tb/tb_float_to_fxp.sv
// Randomized and directed checks of float_to_fxp against a real-arithmetic model.
module tb_float_to_fxp;

  localparam int FRAC = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  float_to_fxp_if bus ();

  float_to_fxp #(.FRAC_BITS(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact value of the float scaled by 2^FRAC, truncated, clamped.
  function automatic logic [31:0] ref_conv(input logic [31:0] f);
    int  e;
    real v;
    e = int'(f[30:23]);
    if (e == 0)   return 32'h0;
    if (e == 255) return (f[22:0] != 0 || !f[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
    v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127 + FRAC));
    if (v >= 2147483648.0) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (f[31]) return 32'(-$rtoi(v));
    return 32'($rtoi(v));
  endfunction

  // One full handshake; reports ready after the first and second edge.
  task automatic run_conv(input logic [31:0] f, output logic [31:0] res,
                          output logic rdy1, output logic rdy2, output logic rdy_after);
    @(negedge clk);
    bus.float_in = f;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    rdy1 = bus.ready;
    @(posedge clk); #1;
    rdy2 = bus.ready;
    res  = bus.fxp_out;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.float_in = $urandom;
    @(posedge clk); #1;
    rdy_after = bus.ready;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.float_in = 32'h3F80_0000;
    #1;
    n_tests++;
    if (bus.ready !== 1'b0 || bus.fxp_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: ready=%b fxp=%h, want 0/00000000", bus.ready, bus.fxp_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: ready=%b want 0", bus.ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] fin [10] = '{32'h3F80_0000, 32'hC020_0000, 32'h3780_0000, 32'h3700_0000,
                              32'h46FF_FF00, 32'hC700_0000, 32'h4780_0000, 32'hFF80_0000,
                              32'h0000_0001, 32'h7FC0_0000};
    logic [31:0] exp_v [10] = '{32'h0001_0000, 32'hFFFD_8000, 32'h0000_0001, 32'h0000_0000,
                                32'h7FFF_8000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                                32'h0000_0000, 32'h7FFF_FFFF};
    logic [31:0] res;
    logic r1, r2, ra;
    for (int i = 0; i < 10; i++) begin
      run_conv(fin[i], res, r1, r2, ra);
      n_tests++;
      if (res !== exp_v[i] || r1 !== 1'b0 || r2 !== 1'b1 || ra !== 1'b0) begin
        n_fail++;
        $display("FAIL directed[%0d] in=%h: fxp=%h ready=%b%b%b, want fxp=%h ready=011",
                 i, fin[i], res, r1, r2, ra, exp_v[i]);
      end
    end
  endtask

  task automatic test_zero_hold();
    logic ok;
    @(negedge clk);
    bus.float_in = 32'h0000_0000;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_first_edge: ready=%b want 0", bus.ready);
    end
    @(negedge clk); bus.float_in = 32'h3F80_0000;
    @(posedge clk); #1;
    n_tests++;
    if (bus.ready !== 1'b1 || bus.fxp_out !== 32'h0) begin
      n_fail++;
      $display("FAIL hold_second_edge: ready=%b fxp=%h want 1/00000000", bus.ready, bus.fxp_out);
    end
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.ready !== 1'b1 || bus.fxp_out !== 32'h0) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL hold_single_conv: ready=%b fxp=%h want 1/00000000", bus.ready, bus.fxp_out);
    end
    @(negedge clk); bus.start = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (bus.ready !== 1'b0 || bus.fxp_out !== 32'h0) begin
      n_fail++;
      $display("FAIL hold_release: ready=%b fxp=%h want 0/00000000", bus.ready, bus.fxp_out);
    end
  endtask

  task automatic test_random();
    logic [31:0] f, res, want;
    logic r1, r2, ra;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      f = $urandom;
      case ($urandom_range(0, 9))
        0:       f[30:23] = 8'd0;
        1:       f[30:23] = 8'd255;
        default: f[30:23] = 8'($urandom_range(100, 150));
      endcase
      want = ref_conv(f);
      run_conv(f, res, r1, r2, ra);
      n_tests++;
      if (res !== want || r2 !== 1'b1 || ra !== 1'b0) begin
        n_fail++;
        if (bad++ < 10)
          $display("FAIL random in=%h: fxp=%h ready=%b%b, want fxp=%h ready=10", f, res, r2, ra, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] f, res;
    logic r1, r2, ra;
    // Boundary neighbours around the saturation points.
    logic [31:0] fin [4] = '{32'h46FF_FFFF, 32'hC700_0001, 32'h4700_0000, 32'hC6FF_FFFF};
    for (int i = 0; i < 4; i++) begin
      f = fin[i];
      run_conv(f, res, r1, r2, ra);
      n_tests++;
      if (res !== ref_conv(f) || r2 !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b[%0d] in=%h: fxp=%h ready=%b, want fxp=%h ready=1", i, f, res, r2, ref_conv(f));
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] res;
    logic r1, r2, ra;
    run_conv(32'hC020_0000, res, r1, r2, ra);
    @(negedge clk);
    bus.float_in = 32'h3F80_0000;
    bus.start    = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.ready !== 1'b0 || bus.fxp_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_in_calc: ready=%b fxp=%h want 0/00000000", bus.ready, bus.fxp_out);
    end
    bus.start = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.ready !== 1'b0 || bus.fxp_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release_idle: ready=%b fxp=%h want 0/00000000", bus.ready, bus.fxp_out);
    end
    run_conv(32'h3F80_0000, res, r1, r2, ra);
    n_tests++;
    if (res !== 32'h0001_0000 || r1 !== 1'b0 || r2 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_then_conv: fxp=%h ready=%b%b want 00010000 ready=01", res, r1, r2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_hold();
    test_random();
    test_back_to_back();
    test_reset_mid_calc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
